// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request port, response
// port, redirect flush and program-load write port.
// With IMEM_ERR_EN defined the response also carries rsp_err.
interface imem_responder_if #(
  parameter int N  = 64,
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [N-1:0]  req_addr;
  logic          flush;
  logic          load_we;
  logic [AW-1:0] load_idx;
  logic [31:0]   load_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [N-1:0]  rsp_addr;
`ifdef IMEM_ERR_EN
  logic          rsp_err;
`endif

  // Fetch unit / program loader side
  modport master (
    output req_valid, req_addr, flush, load_we, load_idx, load_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr
`ifdef IMEM_ERR_EN
    , input rsp_err
`endif
  );

  // Responder side
  modport slave (
    input  req_valid, req_addr, flush, load_we, load_idx, load_data, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr
`ifdef IMEM_ERR_EN
    , output rsp_err
`endif
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch addresses, reads a word-addressed
// instruction RAM in the accept cycle, carries the word through a fixed-latency
// pipeline into a bounded FIFO and returns it tagged with its address.
// Total outstanding fetches (pipeline + queue) are capped at QD so the queue
// never overflows; flush drops everything in flight.
// Optional macro IMEM_ERR_EN: misaligned or out-of-range fetches are returned
// in order with rsp_err=1 and a zero instruction word.
module imem_responder #(
  parameter int N   = 64,
  parameter int AW  = 8,
  parameter int LAT = 2,
  parameter int QD  = 4
) (
  input logic             clk,
  input logic             reset,
  imem_responder_if.slave bus
);
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD + 1);
  localparam int OW = $clog2(QD + LAT + 1);

  typedef struct packed {
    logic [31:0]  instr;
    logic [N-1:0] addr;
    logic         err;
  } ent_t;

  logic [31:0]   mem [2**AW];
  ent_t          q_mem [QD];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [OW-1:0] pipe_cnt;
  logic [OW-1:0] outstanding;
  logic [AW-1:0] req_idx;
  logic          fault;
  logic          accept;
  logic          pop;
  logic          push_vld;
  ent_t          push_ent;
  ent_t          acc_ent;
  ent_t          head;

  assign req_idx = bus.req_addr[AW+1:2];

`ifdef IMEM_ERR_EN
  assign fault = (|bus.req_addr[1:0]) | (|bus.req_addr[N-1:AW+2]);
`else
  // Byte offset and upper address bits are deliberately ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[N-1:AW+2]};
  assign fault = 1'b0;
`endif

  assign accept = bus.req_valid & bus.req_ready & ~bus.flush;
  assign pop    = bus.rsp_valid & bus.rsp_ready;

  // Accept-cycle read: the load write lands at the same edge, so the old word is seen
  assign acc_ent.instr = fault ? 32'h0 : mem[req_idx];
  assign acc_ent.addr  = bus.req_addr;
  assign acc_ent.err   = fault;

  genvar gi;
  generate
    if (LAT == 1) begin : g_direct
      assign push_vld = accept;
      assign push_ent = acc_ent;
      assign pipe_cnt = '0;
    end else begin : g_pipe
      logic stg_vld_reg [LAT-1];
      ent_t stg_ent_reg [LAT-1];

      for (gi = 0; gi < LAT - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          // First stage captures the accepted fetch; flush kills it
          always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
              stg_vld_reg[0] <= 1'b0;
              stg_ent_reg[0] <= '0;
            end else begin
              stg_vld_reg[0] <= accept;
              stg_ent_reg[0] <= acc_ent;
            end
          end
        end else begin : g_next
          // Later stages shift the fetch along; flush kills it
          always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
              stg_vld_reg[gi] <= 1'b0;
              stg_ent_reg[gi] <= '0;
            end else begin
              stg_vld_reg[gi] <= stg_vld_reg[gi-1] & ~bus.flush;
              stg_ent_reg[gi] <= stg_ent_reg[gi-1];
            end
          end
        end
      end

      assign push_vld = stg_vld_reg[LAT-2] & ~bus.flush;
      assign push_ent = stg_ent_reg[LAT-2];

      // Number of fetches currently travelling through the pipeline
      always_comb begin
        pipe_cnt = '0;
        for (int k = 0; k < LAT - 1; k++) begin
          pipe_cnt = pipe_cnt + OW'(stg_vld_reg[k]);
        end
      end
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queue pointers and occupancy; flush empties the queue, push+pop keeps count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_vld) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)      rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(push_vld) - CW'(pop);
    end
  end

  // Queue storage write
  always_ff @(posedge clk) begin
    if (push_vld) q_mem[wr_ptr_reg] <= push_ent;
  end

  // Program-load write into the instruction RAM
  always_ff @(posedge clk) begin
    if (bus.load_we) mem[bus.load_idx] <= bus.load_data;
  end

  assign outstanding   = OW'(count_reg) + pipe_cnt;
  assign bus.req_ready = (outstanding < OW'(QD)) & ~bus.flush;

  assign head          = q_mem[rd_ptr_reg];
  assign bus.rsp_valid = (count_reg != '0);
  assign bus.rsp_instr = bus.rsp_valid ? head.instr : 32'h0;
  assign bus.rsp_addr  = bus.rsp_valid ? head.addr : '0;

`ifdef IMEM_ERR_EN
  assign bus.rsp_err = bus.rsp_valid & head.err;
`else
  logic unused_head_err;
  assign unused_head_err = head.err;
`endif
endmodule
